if_stage: RTL and testbench
===========================

Name: if_stage

Overview:
- Instruction-fetch stage of the RV32 pipeline.
- Holds the program counter (PC) register and presents it as the instruction-memory address.
- Computes the sequential next PC (PC+4).
- Next-PC selection (sequential/branch/jump) happens outside this block and is fed back through pc_in; this block only registers it.

Parameters:
- XLEN, 32, data/address width in bits.
- RESET_PC, 32'h0000_0000, PC value loaded during reset (must be word-aligned).

Ports:
- clock  input  1  single system clock, rising-edge active
- reset  input  1  asynchronous, active-low reset (0 = reset asserted)
- stall  input  1  1 = hold PC this cycle (hazard/memory wait)
- pc_in  input  XLEN  next-PC value chosen by the pipeline, sampled at the clock edge
- pc4  output  XLEN  inst_addr + 4, combinational from the PC register
- inst_addr  output  XLEN  current PC, driven directly from the PC register, to instruction memory

Behaviour:
- Single state element pc_q[XLEN-1:0]; no FSM.
- Reset:
  - reset=0 forces pc_q=RESET_PC immediately, independent of clock.
  - Outputs while in reset: inst_addr=RESET_PC, pc4=RESET_PC+4.
  - Reset mid-operation discards the current PC at once.
- Reset release is synchronous-safe: the first load occurs on the first rising clock edge with reset=1.
- Update on rising edge, reset=1:
  - stall=0: pc_q <= {pc_in[XLEN-1:2], 2'b00}. Low two bits are always cleared; PC is word-aligned by construction.
  - stall=1: pc_q holds; pc_in is ignored.
- Latency: a pc_in value presented before edge N appears on inst_addr right after edge N (one cycle).
- pc4 = pc_q + 4, modulo 2^XLEN. Wrap: pc_q=32'hFFFF_FFFC gives pc4=32'h0000_0000. No carry-out.
- Combinational feedback pc_in=pc4 must not form a loop: pc4 depends only on pc_q.
- pc_in containing X/unknown while stall=1 must not corrupt pc_q.
- Simultaneous reset=0 and clock edge: reset wins; pc_q=RESET_PC.

Optional Feature:
- Macro IF_MISALIGN_CHECK_EN.
- Defined:
  - Adds output port misalign (1 bit), registered.
  - On each load edge (reset=1, stall=0): misalign <= (pc_in[1:0] != 2'b00).
  - Holds during stall; resets to 0.
  - The PC still loads the aligned value; misalign is informational, for the trap unit.
- Not defined: port absent; low bits are silently cleared.

Decomposition:
- Shared package riscv_pkg:
  - XLEN
  - RESET_PC default
  - INST_BYTES=4 constant used for the increment
  - typedef addr_t (logic [XLEN-1:0])
- One natural sub-module: pc_reg (async active-low reset register with enable and alignment masking). The adder stays in if_stage.

Test Plan:
- Reset: hold reset=0 for 10 ns -> inst_addr=0x0, pc4=0x4 with no clock edge required.
- Sequential fetch: release reset, drive pc_in=pc4 each cycle for 5 cycles -> inst_addr steps 0x0,0x4,0x8,0xC,0x10; pc4 always inst_addr+4.
- Stall: at inst_addr=0x8, assert stall for 2 cycles with pc_in=0x40 -> inst_addr stays 0x8; deassert -> 0x40 next edge.
- Branch/wrap: pc_in=0xFFFF_FFFC -> inst_addr=0xFFFF_FFFC, pc4=0x0; next pc_in=pc4 -> inst_addr=0x0.
- Misalignment: pc_in=0x0000_0106 -> inst_addr=0x0000_0104; with IF_MISALIGN_CHECK_EN, misalign=1 for that cycle, 0 after an aligned load.
- Async reset mid-run: at inst_addr=0x20, pull reset low between edges -> inst_addr=0x0 immediately; release -> resumes loading pc_in on the next edge.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32 constants and types for the fetch pipeline.
package riscv_pkg;

    localparam int unsigned XLEN       = 32;
    localparam logic [31:0] RESET_PC   = 32'h0000_0000;
    localparam int unsigned INST_BYTES = 4;

    typedef logic [XLEN-1:0] addr_t;

    function automatic logic is_misaligned(input logic [1:0] lsbs);
        return lsbs != 2'b00;
    endfunction

endpackage

// File: rtl/pc_reg.sv
// PC register: async active-low reset, load enable, word-alignment masking.
// Optional misalignment flag under IF_MISALIGN_CHECK_EN.
module pc_reg
    import riscv_pkg::*;
#(
    parameter int unsigned       Width    = 32,
    parameter logic [Width-1:0]  ResetVal = '0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic [Width-1:0] d_i,
`ifdef IF_MISALIGN_CHECK_EN
    output logic             misalign_o,
`endif
    output logic [Width-1:0] q_o
);

    logic [Width-1:0] pc_d, pc_q;

    // Hold path never looks at d_i, so an unknown d_i cannot leak in while stalled.
    always_comb begin
        pc_d = pc_q;
        if (en_i) begin
            pc_d = {d_i[Width-1:2], 2'b00};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pc_q <= ResetVal;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign q_o = pc_q;

`ifdef IF_MISALIGN_CHECK_EN
    logic misalign_d, misalign_q;

    always_comb begin
        misalign_d = misalign_q;
        if (en_i) begin
            misalign_d = is_misaligned(d_i[1:0]);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= misalign_d;
        end
    end

    assign misalign_o = misalign_q;
`endif

endmodule

// File: rtl/if_stage.sv
// RV32 instruction-fetch stage: PC register plus sequential PC+4 adder.
// Define IF_MISALIGN_CHECK_EN to add the registered misalign output.
module if_stage
    import riscv_pkg::*;
#(
    parameter int unsigned      XLEN     = riscv_pkg::XLEN,
    parameter logic [XLEN-1:0]  RESET_PC = riscv_pkg::RESET_PC
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            stall,
    input  logic [XLEN-1:0] pc_in,
`ifdef IF_MISALIGN_CHECK_EN
    output logic            misalign,
`endif
    output logic [XLEN-1:0] pc4,
    output logic [XLEN-1:0] inst_addr
);

    logic [XLEN-1:0] pc_q;

    pc_reg #(
        .Width    (XLEN),
        .ResetVal (RESET_PC)
    ) u_pc_reg (
        .clk_i      (clock),
        .rst_ni     (reset),
        .en_i       (!stall),
        .d_i        (pc_in),
`ifdef IF_MISALIGN_CHECK_EN
        .misalign_o (misalign),
`endif
        .q_o        (pc_q)
    );

    // Depends on pc_q only, so feeding pc4 back into pc_in never forms a loop.
    assign pc4       = pc_q + XLEN'(INST_BYTES);
    assign inst_addr = pc_q;

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: vector table driven through a scoreboard queue.
module tb_if_stage;

    logic        clock;
    logic        reset;
    logic        stall;
    logic [31:0] pc_in;
    logic [31:0] pc4;
    logic [31:0] inst_addr;
`ifdef IF_MISALIGN_CHECK_EN
    logic        misalign;
`endif

    int checks   = 0;
    int failures = 0;
    bit clk_en   = 0;

    if_stage dut (
        .clock     (clock),
        .reset     (reset),
        .stall     (stall),
        .pc_in     (pc_in),
`ifdef IF_MISALIGN_CHECK_EN
        .misalign  (misalign),
`endif
        .pc4       (pc4),
        .inst_addr (inst_addr)
    );

    initial begin
        clock = 0;
        wait (clk_en);
        forever #5 clock = ~clock;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    typedef struct {
        bit          stall;
        bit          use_pc4;
        logic [31:0] pc_in;
        logic [31:0] exp_addr;
        bit          exp_mis;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        bit          mis;
        int          idx;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] last_exp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
        end
    endtask

    task automatic compare_outputs(input string tag, input exp_t e);
        check($sformatf("%s inst_addr", tag), inst_addr, e.addr);
        check($sformatf("%s pc4", tag), pc4, e.addr + 32'd4);
`ifdef IF_MISALIGN_CHECK_EN
        check($sformatf("%s misalign", tag), {31'b0, misalign}, {31'b0, e.mis});
`endif
    endtask

    // Drive one cycle at the falling edge, push the expectation, compare after the rising edge.
    task automatic step(input int idx, input vec_t v);
        exp_t e;
        @(negedge clock);
        stall = v.stall;
        pc_in = v.use_pc4 ? last_exp + 32'd4 : v.pc_in;
        e.addr = v.exp_addr;
        e.mis  = v.exp_mis;
        e.idx  = idx;
        sb.push_back(e);
        @(posedge clock);
        #1;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard: got empty queue, required an entry");
        end else begin
            e = sb.pop_front();
            compare_outputs($sformatf("vec%0d", e.idx), e);
            last_exp = e.addr;
        end
    endtask

    vec_t vecs[16];

    initial begin
        exp_t e;
        vec_t v;

        vecs[0]  = '{0, 1, 32'h0,         32'h0000_0004, 0};
        vecs[1]  = '{0, 1, 32'h0,         32'h0000_0008, 0};
        vecs[2]  = '{0, 1, 32'h0,         32'h0000_000C, 0};
        vecs[3]  = '{0, 1, 32'h0,         32'h0000_0010, 0};
        vecs[4]  = '{0, 0, 32'h0000_0008, 32'h0000_0008, 0};
        vecs[5]  = '{1, 0, 32'h0000_0040, 32'h0000_0008, 0};
        vecs[6]  = '{1, 0, 32'h0000_0040, 32'h0000_0008, 0};
        vecs[7]  = '{0, 0, 32'h0000_0040, 32'h0000_0040, 0};
        vecs[8]  = '{0, 0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 0};
        vecs[9]  = '{0, 1, 32'h0,         32'h0000_0000, 0};
        vecs[10] = '{0, 0, 32'h0000_0106, 32'h0000_0104, 1};
        vecs[11] = '{1, 0, 32'hDEAD_BEEF, 32'h0000_0104, 1};
        vecs[12] = '{0, 1, 32'h0,         32'h0000_0108, 0};
        vecs[13] = '{0, 0, 32'h0000_0023, 32'h0000_0020, 1};
        vecs[14] = '{1, 0, 32'h0000_0011, 32'h0000_0020, 1};
        vecs[15] = '{0, 0, 32'h0000_0020, 32'h0000_0020, 0};

        // Reset with no clock edge at all.
        reset = 1;
        stall = 0;
        pc_in = 32'h0000_0050;
        #1 reset = 0;
        #9;
        e = '{32'h0, 0, 0};
        compare_outputs("reset_noclk", e);

        // Edges while reset is held must not load pc_in.
        clk_en = 1;
        @(posedge clock);
        @(posedge clock);
        #1;
        compare_outputs("reset_held", e);

        // Release between edges: nothing loads until the next rising edge.
        @(negedge clock);
        reset = 1;
        #1;
        compare_outputs("release", e);
        last_exp = 32'h0;

        for (int i = 0; i < 16; i++) begin
            v = vecs[i];
            step(i, v);
        end

        // Async reset mid-run at inst_addr=0x20, between edges.
        @(negedge clock);
        stall = 0;
        pc_in = 32'h0000_0080;
        #1 reset = 0;
        #1;
        compare_outputs("async_rst", e);
        @(posedge clock);
        #1;
        compare_outputs("rst_over_edge", e);
        @(negedge clock);
        reset = 1;
        last_exp = 32'h0;
        v = '{0, 0, 32'h0000_0030, 32'h0000_0030, 0};
        step(100, v);
        v = '{0, 1, 32'h0,         32'h0000_0034, 0};
        step(101, v);

        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d leftover, required 0", sb.size());
        end
        checks++;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
